// File: rtl/jk_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jk_shift_ctrl
//  Description : Paced load/shift/rotate sequencer driving a bank of negedge
//                JK flip-flops through per-bit J/K lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_shift_ctrl #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int DIV_W    = 27
) (
  input  logic             Clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_OP_LOAD = 2'b00;
  localparam logic [1:0] c_OP_SHL  = 2'b01;
  localparam logic [1:0] c_OP_SHR  = 2'b10;
  localparam logic [1:0] c_OP_ROTR = 2'b11;

  localparam logic [DIV_W-1:0] c_TICK_RELOAD = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_op;
  logic [CNT_W-1:0]   r_rem;
  logic [DIV_W-1:0]   r_tick;
  logic [WIDTH-1:0]   w_next;

  // Next register image, built from the bank's current Q at the step edge.
  always_comb begin
    w_next = q_fb;
    case (r_op)
      c_OP_SHL:  w_next = {q_fb[WIDTH-2:0], ser_in};
      c_OP_SHR:  w_next = {ser_in, q_fb[WIDTH-1:1]};
      c_OP_ROTR: w_next = {q_fb[0], q_fb[WIDTH-1:1]};
      default:   w_next = q_fb;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!clear) begin
      r_state   <= S_IDLE;
      r_op      <= c_OP_LOAD;
      r_rem     <= '0;
      r_tick    <= '0;
      jk_j      <= '0;
      jk_k      <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_op      <= cmd_op;
            r_rem     <= cmd_count;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op == c_OP_LOAD) begin
              jk_j    <= cmd_data;
              jk_k    <= ~cmd_data;
              r_state <= S_STEP;
            end else if (cmd_count == '0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_tick  <= c_TICK_RELOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_tick == '0) begin
            jk_j    <= w_next;
            jk_k    <= ~w_next;
            r_rem   <= r_rem - 1'b1;
            r_state <= S_STEP;
          end else begin
            r_tick  <= r_tick - 1'b1;
          end
        end
        S_STEP: begin
          // J/K held for exactly one cycle; the bank samples at the negedge.
          jk_j <= '0;
          jk_k <= '0;
          if ((r_op == c_OP_LOAD) || (r_rem == '0)) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tick  <= c_TICK_RELOAD;
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_shift_ctrl
//  Description : Bench for jk_shift_ctrl with a looped-back negedge JK bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_shift_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int TD = 4;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          ser_in = 1'b0;
  logic [W-1:0]  q_fb = '0;
  logic [W-1:0]  jk_j, jk_k;
  logic          cmd_ready, busy, done;

  int n_chk = 0;
  int n_pass = 0;

  jk_shift_ctrl #(.WIDTH(W), .CNT_W(CW), .TICK_DIV(TD), .DIV_W(DW)) dut (
    .Clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .ser_in(ser_in), .q_fb(q_fb), .jk_j(jk_j), .jk_k(jk_k),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  // Negedge JK flip-flop bank
  always @(negedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({jk_j[i], jk_k[i]})
        2'b01:   q_fb[i] <= 1'b0;
        2'b10:   q_fb[i] <= 1'b1;
        2'b11:   q_fb[i] <= ~q_fb[i];
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int ref_next(input int op, input int q, input int s, input int data);
    case (op)
      0:       return data;
      1:       return ((q << 1) | s) & 255;
      2:       return (q >> 1) | (s << 7);
      default: return (q >> 1) | ((q & 1) << 7);
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 100 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) chk({tag, " ready timeout"}, 0, 1);
  endtask

  // Issues one command and checks it cycle by cycle against the model.
  // inj >= 0 offers a spurious load of 0x00 at that offset while busy.
  task automatic run_cmd(input int op, input int cnt, input int data, input int ser,
                         input int inj, input string tag);
    int q_exp, nsteps, step_idx, step_off, done_off, last_off, nxt;
    int nz, n_done, done_at, q_bad, hs_bad;
    wait_ready(tag);
    q_exp     = int'(q_fb);
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_count = cnt[CW-1:0];
    cmd_data  = data[W-1:0];
    ser_in    = ser[0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    nsteps   = (op == 0) ? 1 : cnt;
    step_off = (op == 0) ? 0 : TD;
    done_off = (op == 0) ? 1 : (cnt == 0) ? 0 : TD + (cnt - 1) * (TD + 1) + 1;
    last_off = done_off + 1;
    step_idx = 0; nz = 0; n_done = 0; done_at = -1; q_bad = 0; hs_bad = 0;
    for (int off = 0; off <= last_off; off++) begin
      if (off > 0) begin @(posedge clk); #1; end
      cmd_valid = 1'b0;
      if (int'(q_fb) != q_exp) q_bad++;
      if ((jk_j | jk_k) != '0) nz++;
      if (step_idx < nsteps && off == step_off) begin
        nxt = ref_next(op, q_exp, ser, data);
        chk({tag, " jk_j"}, 32'(jk_j), 32'(nxt));
        chk({tag, " jk_k"}, 32'(jk_k), 32'(~nxt & 255));
        q_exp = nxt;
        step_idx++;
        step_off += TD + 1;
      end
      if (done) begin n_done++; done_at = off; end
      if (busy != (off <= done_off)) hs_bad++;
      if (cmd_ready != (off > done_off)) hs_bad++;
      if (off == inj) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = '0;
      end
    end
    cmd_valid = 1'b0;
    chk({tag, " jk active cycles"}, nz, nsteps);
    chk({tag, " done pulses"}, n_done, 1);
    chk({tag, " done offset"}, done_at, done_off);
    chk({tag, " q tracking errors"}, q_bad, 0);
    chk({tag, " ready/busy errors"}, hs_bad, 0);
    chk({tag, " final q"}, 32'(q_fb), 32'(q_exp));
  endtask

  initial begin
    int nz, nd;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cmd_ready", 32'(cmd_ready), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset jk", 32'({jk_j, jk_k}), 0);
    clear = 1'b1;
    @(posedge clk); #1;

    run_cmd(0, 0, 8'hA5, 0, -1, "load A5");
    chk("load A5 q", 32'(q_fb), 32'hA5);
    run_cmd(0, 0, 8'h81, 0, -1, "load 81");
    run_cmd(1, 3, 0, 1, -1, "shl3");
    chk("shl3 q", 32'(q_fb), 32'h0F);
    run_cmd(0, 0, 8'hF0, 0, -1, "load F0");
    run_cmd(2, 2, 0, 0, -1, "shr2");
    chk("shr2 q", 32'(q_fb), 32'h3C);
    run_cmd(0, 0, 8'h5A, 0, -1, "load 5A");
    run_cmd(3, 8, 0, 0, -1, "rotr8");
    chk("rotr8 q", 32'(q_fb), 32'h5A);
    run_cmd(1, 0, 0, 1, -1, "count0");
    chk("count0 q", 32'(q_fb), 32'h5A);

    // Reset while waiting between steps
    run_cmd(0, 0, 8'h3C, 0, -1, "load 3C");
    wait_ready("abort");
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd5; ser_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    chk("abort jk", 32'({jk_j, jk_k}), 0);
    chk("abort cmd_ready", 32'(cmd_ready), 1);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    clear = 1'b1;
    nz = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if ((jk_j | jk_k) != '0) nz++;
      if (done) nd++;
    end
    chk("abort quiet jk", nz, 0);
    chk("abort quiet done", nd, 0);
    chk("abort q holds", 32'(q_fb), 32'h3C);
    run_cmd(0, 0, 8'h99, 0, -1, "load after abort");

    // Offer during busy must be ignored
    run_cmd(2, 2, 0, 1, 2, "ignore busy");
    chk("ignore busy q", 32'(q_fb), 32'hE6);

    for (int n = 0; n < 20; n++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
              -1, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
